// File: rtl/start_signal_pulse_pio.sv
// Avalon-MM PIO output port with set/clear/data access and a retriggerable timed pulse.
// A PULSE write raises the selected bits for exactly L cycles; the mask records which bits to drop at expiry.
module start_signal_pulse_pio #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    typedef enum logic [2:0] {
        REG_DATA  = 3'd0,
        REG_SET   = 3'd1,
        REG_CLEAR = 3'd2,
        REG_PLEN  = 3'd3,
        REG_PULSE = 3'd4,
        REG_COUNT = 3'd5,
        REG_RSVD6 = 3'd6,
        REG_RSVD7 = 3'd7
    } reg_addr_e;

    localparam logic [WIDTH-1:0] OUT_RESET = RESET_VALUE[WIDTH-1:0];

    reg_addr_e        reg_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic [CNT_W-1:0] wr_len;
    logic             unused_wdata;

    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic             pulse_start;
    logic             expire;

    assign reg_sel      = reg_addr_e'(address);
    assign wr_en        = chipselect && !write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign wr_len       = writedata[CNT_W-1:0];
    assign unused_wdata = ^writedata;

    // A PULSE write with a zero length is dropped entirely, so it neither reloads nor blocks expiry.
    assign pulse_start = wr_en && (reg_sel == REG_PULSE) && (plen_q != '0);
    assign expire      = !pulse_start && (cnt_q == CNT_W'(1));

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        plen_d = plen_q;

        if (pulse_start) begin
            out_d  = out_q | wr_bits;
            mask_d = mask_q | wr_bits;
            cnt_d  = plen_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (expire) begin
                out_d  = out_q & ~mask_q;
                mask_d = '0;
            end
        end

        // Register writes layer on top of the expiry result so written bits win.
        if (wr_en) begin
            case (reg_sel)
                REG_DATA:  out_d = wr_bits;
                REG_SET:   out_d = out_d | wr_bits;
                REG_CLEAR: begin
                    out_d  = out_d & ~wr_bits;
                    mask_d = mask_d & ~wr_bits;
                end
                REG_PLEN:  plen_d = wr_len;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= OUT_RESET;
            mask_q <= '0;
            plen_q <= '0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            plen_q <= plen_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (reg_sel)
            REG_DATA:  readdata = 32'(out_q);
            REG_PLEN:  readdata = 32'(plen_q);
            REG_PULSE: readdata = 32'(mask_q);
            REG_COUNT: readdata = 32'(cnt_q);
            default:   readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_start_signal_pulse_pio.sv
// Bench for start_signal_pulse_pio: directed pulse scenarios plus random register traffic,
// checked each cycle against a deadline-based reference model through an expectation queue.
module tb_start_signal_pulse_pio;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 16;
    localparam logic [31:0] RV = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;
    logic          busy;

    always #5 clk = ~clk;

    start_signal_pulse_pio #(
        .WIDTH      (W),
        .CNT_W      (CW),
        .RESET_VALUE(RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         bsy;
        logic [31:0]  rd;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    string phase = "init";

    // Reference model: pulse end is an absolute edge number rather than a down-counter.
    logic [W-1:0] m_out;
    logic [W-1:0] m_mask;
    int unsigned  m_len;
    longint       now = 0;
    longint       deadline = 0;
    bit           m_valid = 0;

    function automatic int unsigned m_count();
        return (deadline > now) ? int'(deadline - now) : 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_out);
            3'd3:    return m_len;
            3'd4:    return 32'(m_mask);
            3'd5:    return m_count();
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic rst, input logic we, input logic [2:0] a, input logic [31:0] wd);
        logic [W-1:0] bits;
        bits = wd[W-1:0];
        now++;
        if (rst) begin
            m_out    = RV[W-1:0];
            m_mask   = '0;
            m_len    = 0;
            deadline = 0;
            m_valid  = 1;
        end else begin
            if (we && a == 3'd4 && m_len != 0) begin
                m_out    = m_out | bits;
                m_mask   = m_mask | bits;
                deadline = now + longint'(m_len);
            end else if (deadline != 0 && now == deadline) begin
                m_out    = m_out & ~m_mask;
                m_mask   = '0;
                deadline = 0;
            end
            if (we) begin
                case (a)
                    3'd0: m_out = bits;
                    3'd1: m_out = m_out | bits;
                    3'd2: begin
                        m_out  = m_out & ~bits;
                        m_mask = m_mask & ~bits;
                    end
                    3'd3: m_len = int'(wd[CW-1:0]);
                    default: ;
                endcase
            end
        end
    endtask

    // One cycle of stimulus: expectation for the pre-edge state is queued, then the model steps.
    task automatic drive(input logic rst, input logic we, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        int unsigned pick;
        @(negedge clk);
        reset     = rst;
        address   = a;
        writedata = wd;
        if (we) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else begin
            pick       = $urandom_range(0, 2);
            chipselect = (pick == 1);
            write_n    = (pick != 2);
        end
        if (m_valid) begin
            e.out = m_out;
            e.bsy = (m_count() != 0);
            e.rd  = m_read(a);
            e.tag = phase;
            q.push_back(e);
        end
        m_step(rst, we, a, wd);
    endtask

    task automatic idle(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, a, $urandom);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        drive(1'b0, 1'b1, a, wd);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (out_port !== e.out) begin
                    fails++;
                    $display("FAIL out_port [%s] t=%0t: got %h expected %h", e.tag, $time, out_port, e.out);
                end
                tests++;
                if (busy !== e.bsy) begin
                    fails++;
                    $display("FAIL busy [%s] t=%0t: got %b expected %b", e.tag, $time, busy, e.bsy);
                end
                tests++;
                if (readdata !== e.rd) begin
                    fails++;
                    $display("FAIL readdata [%s] addr=%0d t=%0t: got %h expected %h",
                             e.tag, address, $time, readdata, e.rd);
                end
            end
        end
    end

    initial begin : stimulus
        logic [2:0]  a;
        logic [31:0] wd;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        phase = "reset";
        drive(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 3'd0, 32'd0);
        idle(3'd0, 1);
        idle(3'd3, 1);
        idle(3'd5, 1);

        phase = "data_clear_set";
        wr(3'd0, 32'd3);
        wr(3'd2, 32'd1);
        wr(3'd1, 32'd1);
        idle(3'd0, 2);

        phase = "pulse_len4";
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h05);
        idle(3'd5, 6);

        phase = "retrigger";
        wr(3'd4, 32'h01);
        idle(3'd4, 1);
        wr(3'd4, 32'h02);
        idle(3'd5, 6);

        phase = "expiry_vs_data";
        wr(3'd3, 32'd3);
        wr(3'd4, 32'h01);
        idle(3'd5, 2);
        wr(3'd0, 32'h01);
        idle(3'd0, 3);

        phase = "plen_zero";
        wr(3'd3, 32'd0);
        wr(3'd4, 32'hFF);
        idle(3'd0, 2);

        phase = "reset_mid_pulse";
        wr(3'd3, 32'd10);
        wr(3'd4, 32'h0F);
        idle(3'd5, 2);
        drive(1'b1, 1'b0, 3'd5, 32'd0);
        idle(3'd5, 6);
        idle(3'd3, 6);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            a = 3'($urandom_range(0, 7));
            if (a == 3'd3)
                wd = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(0, 8);
            else
                wd = $urandom;
            if ($urandom_range(0, 255) == 0)
                drive(1'b1, 1'b0, a, wd);
            else
                drive(1'b0, ($urandom_range(0, 2) == 0), a, wd);
        end
        idle(3'd5, 3);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
